// File: rtl/scan_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// scan_pkg
// Shared widths, default step and the controller state encoding.
// Revision: 1.0
// =============================================================================
package scan_pkg;

    localparam int DW_ANGLE   = 8;
    localparam int DW_INPUT   = 8;
    localparam int DW_POINTS  = 13;
    localparam int DW_GAP     = 16;
    localparam int ANGLE_STEP = 10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP     = 3'd1,
        S_FIRE      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4,
        S_DRAIN     = 3'd5,
        S_FINISH    = 3'd6
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/scan_sequencer_if.sv
`default_nettype none
// =============================================================================
// scan_sequencer_if
// Control, configuration and Transmitter-side signals of the scan sequencer.
// Optional SCAN_CONTINUOUS_EN adds the cont input.
// Revision: 1.0
// =============================================================================
interface scan_sequencer_if
    import scan_pkg::*;
#(
    parameter int DW_ANGLE  = scan_pkg::DW_ANGLE,
    parameter int DW_INPUT  = scan_pkg::DW_INPUT,
    parameter int DW_POINTS = scan_pkg::DW_POINTS,
    parameter int DW_GAP    = scan_pkg::DW_GAP
) ();

    logic                 start;
    logic                 abort;
`ifdef SCAN_CONTINUOUS_EN
    logic                 cont;
`endif
    logic [DW_ANGLE-1:0]  cfg_angle_start;
    logic [DW_ANGLE-1:0]  cfg_angle_end;
    logic [DW_ANGLE-1:0]  cfg_angle_step;
    logic [DW_INPUT-1:0]  cfg_r_0;
    logic [DW_POINTS-1:0] cfg_num_points;
    logic [DW_GAP-1:0]    cfg_gap;
    logic                 tx_done;

    logic [DW_INPUT-1:0]  r_0;
    logic [DW_ANGLE-1:0]  angle;
    logic [DW_POINTS-1:0] num_points;
    logic                 initiate;
    logic                 busy;
    logic [7:0]           line_idx;
    logic                 frame_done;
    logic                 cfg_err;

    modport master (
`ifdef SCAN_CONTINUOUS_EN
        output cont,
`endif
        output start, abort, cfg_angle_start, cfg_angle_end, cfg_angle_step,
               cfg_r_0, cfg_num_points, cfg_gap, tx_done,
        input  r_0, angle, num_points, initiate, busy, line_idx, frame_done, cfg_err
    );

    modport slave (
`ifdef SCAN_CONTINUOUS_EN
        input  cont,
`endif
        input  start, abort, cfg_angle_start, cfg_angle_end, cfg_angle_step,
               cfg_r_0, cfg_num_points, cfg_gap, tx_done,
        output r_0, angle, num_points, initiate, busy, line_idx, frame_done, cfg_err
    );

endinterface
`default_nettype wire

// File: rtl/scan_sequencer_gap_timer.sv
`default_nettype none
// =============================================================================
// gap_timer
// Loadable down-counter timing the dead-time between scanlines.
// Revision: 1.0
// =============================================================================
module gap_timer
    import scan_pkg::*;
#(
    parameter int DW_GAP = scan_pkg::DW_GAP
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              load_i,
    input  wire              en_i,
    input  wire [DW_GAP-1:0] load_val_i,
    output logic             expire_o
);

    logic [DW_GAP-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted on the cycle whose decrement lands on 1, so the owner leaves
    // its wait state exactly load_val cycles after the cycle preceding the load.
    assign expire_o = en_i && (cnt_q <= DW_GAP'(2));

endmodule
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// =============================================================================
// scan_sequencer
// Steps scanline angles start..end, fires one Transmitter line per angle and
// spaces lines by a programmable dead-time. SCAN_CONTINUOUS_EN: repeat frames.
// Revision: 1.0
// =============================================================================
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DW_ANGLE  = scan_pkg::DW_ANGLE,
    parameter int DW_INPUT  = scan_pkg::DW_INPUT,
    parameter int DW_POINTS = scan_pkg::DW_POINTS,
    parameter int DW_GAP    = scan_pkg::DW_GAP
) (
    input wire              clk,
    input wire              rst,
    scan_sequencer_if.slave bus
);

    scan_state_t          state_q, state_d;
    logic [DW_ANGLE-1:0]  end_q, end_d, step_q, step_d, cur_q, cur_d;
    logic [DW_INPUT-1:0]  r0_cfg_q, r0_cfg_d;
    logic [DW_POINTS-1:0] np_cfg_q, np_cfg_d;
    logic [DW_GAP-1:0]    gap_q, gap_d;
    logic [7:0]           line_q, line_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [DW_ANGLE-1:0]  ang_out_q;
    logic [DW_INPUT-1:0]  r0_out_q;
    logic [DW_POINTS-1:0] np_out_q;
`ifdef SCAN_CONTINUOUS_EN
    logic [DW_ANGLE-1:0]  ang_start_q, ang_start_d;
`endif

    logic                 w_tmr_load, w_tmr_en, w_tmr_expire;
    logic [DW_ANGLE:0]    w_nxt;
    logic                 w_last, w_gap_short, w_enter_setup;

    assign w_nxt       = {1'b0, cur_q} + {1'b0, step_q};
    assign w_last      = (step_q == '0) || w_nxt[DW_ANGLE] || (w_nxt[DW_ANGLE-1:0] > end_q);
    // A one-cycle gap already equals the direct path's spacing.
    assign w_gap_short = (gap_q <= DW_GAP'(1));

    gap_timer #(.DW_GAP(DW_GAP)) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_tmr_load),
        .en_i       (w_tmr_en),
        .load_val_i (gap_q),
        .expire_o   (w_tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        end_d      = end_q;
        step_d     = step_q;
        cur_d      = cur_q;
        r0_cfg_d   = r0_cfg_q;
        np_cfg_d   = np_cfg_q;
        gap_d      = gap_q;
        line_d     = line_q;
        cfg_err_d  = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;
`ifdef SCAN_CONTINUOUS_EN
        ang_start_d = ang_start_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_angle_start > bus.cfg_angle_end) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        end_d    = bus.cfg_angle_end;
                        step_d   = bus.cfg_angle_step;
                        r0_cfg_d = bus.cfg_r_0;
                        np_cfg_d = bus.cfg_num_points;
                        gap_d    = bus.cfg_gap;
                        cur_d    = bus.cfg_angle_start;
                        line_d   = '0;
`ifdef SCAN_CONTINUOUS_EN
                        ang_start_d = bus.cfg_angle_start;
`endif
                        state_d  = S_SETUP;
                    end
                end
            end
            S_SETUP: state_d = bus.abort ? S_IDLE : S_FIRE;
            S_FIRE:  state_d = bus.abort ? S_DRAIN : S_WAIT_DONE;
            S_WAIT_DONE: begin
                // A done arriving together with abort leaves nothing to drain.
                if (bus.abort) begin
                    state_d = bus.tx_done ? S_IDLE : S_DRAIN;
                end else if (bus.tx_done) begin
                    if (w_last) begin
                        state_d = S_FINISH;
                    end else begin
                        cur_d  = w_nxt[DW_ANGLE-1:0];
                        line_d = (line_q == 8'hFF) ? 8'hFF : line_q + 8'd1;
                        if (w_gap_short) begin
                            state_d = S_SETUP;
                        end else begin
                            state_d    = S_GAP;
                            w_tmr_load = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                w_tmr_en = 1'b1;
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (w_tmr_expire) begin
                    state_d = S_SETUP;
                end
            end
            S_DRAIN: begin
                if (bus.tx_done) begin
                    state_d = S_IDLE;
                end
            end
            S_FINISH: begin
`ifdef SCAN_CONTINUOUS_EN
                if (bus.cont) begin
                    cur_d  = ang_start_q;
                    line_d = '0;
                    if (w_gap_short) begin
                        state_d = S_SETUP;
                    end else begin
                        state_d    = S_GAP;
                        w_tmr_load = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transmitter-facing words change only on the edge entering SETUP.
    assign w_enter_setup = (state_d == S_SETUP) && (state_q != S_SETUP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            end_q     <= '0;
            step_q    <= '0;
            cur_q     <= '0;
            r0_cfg_q  <= '0;
            np_cfg_q  <= '0;
            gap_q     <= '0;
            line_q    <= '0;
            cfg_err_q <= 1'b0;
            ang_out_q <= '0;
            r0_out_q  <= '0;
            np_out_q  <= '0;
`ifdef SCAN_CONTINUOUS_EN
            ang_start_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            end_q     <= end_d;
            step_q    <= step_d;
            cur_q     <= cur_d;
            r0_cfg_q  <= r0_cfg_d;
            np_cfg_q  <= np_cfg_d;
            gap_q     <= gap_d;
            line_q    <= line_d;
            cfg_err_q <= cfg_err_d;
`ifdef SCAN_CONTINUOUS_EN
            ang_start_q <= ang_start_d;
`endif
            if (w_enter_setup) begin
                ang_out_q <= cur_d;
                r0_out_q  <= r0_cfg_d;
                np_out_q  <= np_cfg_d;
            end
        end
    end

    assign bus.r_0        = r0_out_q;
    assign bus.angle      = ang_out_q;
    assign bus.num_points = np_out_q;
    assign bus.initiate   = (state_q == S_FIRE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.line_idx   = line_q;
    assign bus.frame_done = (state_q == S_FINISH);
    assign bus.cfg_err    = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// =============================================================================
// tb_scan_sequencer
// Scoreboard bench: expected scanlines queued at start, checked at initiate.
// Revision: 1.0
// =============================================================================
module tb_scan_sequencer;
    import scan_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scan_sequencer_if bus ();

    scan_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int angle;
        int idx;
        int r0;
        int np;
    } line_t;

    line_t exp_q[$];
    int    checks = 0, failures = 0;
    int    cyc = 0, n_init = 0, n_fd = 0, n_err = 0, n_tx = 0;
    int    last_tx_cyc = 0, last_init_cyc = 0, last_fd_cyc = 0;
    int    tx_cnt = 0, tx_lat = 10, exp_spacing = -1;
    bit    have_tx = 1'b0;

    wire [40:0] w_outs = {bus.r_0, bus.angle, bus.num_points, bus.initiate,
                          bus.busy, bus.line_idx, bus.frame_done, bus.cfg_err};

    // Reference model of one frame's line list.
    function automatic void push_frame(input int s, input int e, input int st,
                                       input int r0, input int np);
        int a   = s;
        int idx = 0;
        while (1) begin
            exp_q.push_back('{a, idx, r0, np});
            if (st == 0) break;
            a = a + st;
            if (a > e) break;
            idx = (idx < 255) ? idx + 1 : 255;
        end
    endfunction

    // Transmitter model and scoreboard consumer.
    initial begin : mon
        line_t e;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.initiate === 1'b1) begin
                n_init++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_initiate angle=%0d line_idx=%0d", bus.angle, bus.line_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(bus.angle) !== e.angle || int'(bus.line_idx) !== e.idx ||
                        int'(bus.r_0) !== e.r0 || int'(bus.num_points) !== e.np) begin
                        failures++;
                        $display("FAIL line_fields got angle=%0d idx=%0d r_0=%0d np=%0d expected angle=%0d idx=%0d r_0=%0d np=%0d",
                                 bus.angle, bus.line_idx, bus.r_0, bus.num_points, e.angle, e.idx, e.r0, e.np);
                    end
                end
                if (exp_spacing >= 0 && have_tx) begin
                    checks++;
                    if (cyc - last_tx_cyc !== exp_spacing) begin
                        failures++;
                        $display("FAIL line_spacing got=%0d expected=%0d", cyc - last_tx_cyc, exp_spacing);
                    end
                end
                last_init_cyc = cyc;
                tx_cnt = tx_lat + 1;
            end
            if (bus.frame_done === 1'b1) begin
                n_fd++;
                last_fd_cyc = cyc;
            end
            if (bus.cfg_err === 1'b1) n_err++;
            if (tx_cnt > 0) begin
                tx_cnt--;
                bus.tx_done = (tx_cnt == 0);
                if (tx_cnt == 0) begin
                    last_tx_cyc = cyc;
                    have_tx = 1'b1;
                    n_tx++;
                end
            end else begin
                bus.tx_done = 1'b0;
            end
        end
    end

    task automatic kick(input int s, input int e, input int st, input int r0,
                        input int np, input int gap, output int drive_cyc);
        @(negedge clk); #1;
        bus.cfg_angle_start = 8'(s);
        bus.cfg_angle_end   = 8'(e);
        bus.cfg_angle_step  = 8'(st);
        bus.cfg_r_0         = 8'(r0);
        bus.cfg_num_points  = 13'(np);
        bus.cfg_gap         = 16'(gap);
        bus.start           = 1'b1;
        have_tx             = 1'b0;
        drive_cyc           = cyc;
        @(negedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (w_outs !== 41'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0", w_outs);
        end
        rst = 1'b0;
    endtask

    task automatic test_frame_basic();
        int d;
        int i0 = n_init;
        int f0 = n_fd;
        tx_lat = 100;
        exp_spacing = 2;
        push_frame(50, 130, 20, 70, 2990);
        kick(50, 130, 20, 70, 2990, 0, d);
        for (int i = 0; i < 1000 && n_init < i0 + 2; i++) begin @(negedge clk); #1; end
        // A start while busy must not disturb the frame.
        bus.cfg_angle_start = 8'd0;
        bus.cfg_angle_end   = 8'd255;
        bus.cfg_r_0         = 8'd1;
        bus.start           = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 2000 && n_fd == f0; i++) begin @(negedge clk); #1; end
        checks++;
        if (n_init - i0 !== 5) begin failures++; $display("FAIL basic_line_count got=%0d expected=5", n_init - i0); end
        checks++;
        if (n_fd - f0 !== 1) begin failures++; $display("FAIL basic_frame_done got=%0d expected=1", n_fd - f0); end
        checks++;
        if (last_fd_cyc - last_tx_cyc !== 1) begin
            failures++; $display("FAIL basic_done_delay got=%0d expected=1", last_fd_cyc - last_tx_cyc);
        end
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL basic_leftover got=%0d expected=0", exp_q.size()); end
        checks++;
        if (bus.r_0 !== 8'd70) begin failures++; $display("FAIL basic_r0_hold got=%0d expected=70", bus.r_0); end
        exp_spacing = -1;
    endtask

    task automatic test_single_line();
        int d;
        int i0 = n_init;
        int f0 = n_fd;
        tx_lat = 20;
        push_frame(90, 90, 5, 33, 100);
        kick(90, 90, 5, 33, 100, 0, d);
        checks++;
        if (bus.angle !== 8'd90 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL single_setup got angle=%0d busy=%0b expected angle=90 busy=1", bus.angle, bus.busy);
        end
        for (int i = 0; i < 200 && n_fd == f0; i++) begin @(negedge clk); #1; end
        checks++;
        if (last_init_cyc - d !== 2) begin
            failures++; $display("FAIL start_to_initiate got=%0d expected=2", last_init_cyc - d);
        end
        checks++;
        if (n_init - i0 !== 1) begin failures++; $display("FAIL single_line_count got=%0d expected=1", n_init - i0); end
        checks++;
        if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL single_frame_done got=%0b expected=1", bus.frame_done); end
        @(negedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++; $display("FAIL single_idle got busy=%0b fd=%0b expected 0 0", bus.busy, bus.frame_done);
        end
    endtask

    task automatic test_cfg_err();
        int d;
        int i0 = n_init;
        int e0 = n_err;
        kick(130, 50, 20, 70, 100, 0, d);
        checks++;
        if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL cfg_err_pulse got err=%0b busy=%0b expected 1 0", bus.cfg_err, bus.busy);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL cfg_err_width got err=%0b busy=%0b expected 0 0", bus.cfg_err, bus.busy);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (n_init !== i0 || n_err - e0 !== 1) begin
            failures++; $display("FAIL cfg_err_effect got initiates=%0d errs=%0d expected 0 1", n_init - i0, n_err - e0);
        end
    endtask

    task automatic test_overflow();
        int d;
        int i0 = n_init;
        int f0 = n_fd;
        tx_lat = 20;
        exp_spacing = 9;
        push_frame(240, 255, 10, 5, 64);
        kick(240, 255, 10, 5, 64, 8, d);
        for (int i = 0; i < 500 && n_fd == f0; i++) begin @(negedge clk); #1; end
        checks++;
        if (n_init - i0 !== 2 || n_fd - f0 !== 1) begin
            failures++; $display("FAIL overflow_lines got lines=%0d fd=%0d expected 2 1", n_init - i0, n_fd - f0);
        end
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL overflow_leftover got=%0d expected=0", exp_q.size()); end
        exp_spacing = -1;
    endtask

    task automatic test_abort_drain();
        int d, tx0;
        int i0 = n_init;
        int f0 = n_fd;
        tx_lat = 30;
        push_frame(50, 90, 20, 70, 200);
        kick(50, 130, 20, 70, 200, 0, d);
        for (int i = 0; i < 500 && n_init < i0 + 3; i++) begin @(negedge clk); #1; end
        repeat (5) @(negedge clk);
        #1;
        tx0 = n_tx;
        bus.abort = 1'b1;
        @(negedge clk); #1;
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL drain_busy got=%0b expected=1", bus.busy); end
        for (int i = 0; i < 100 && n_tx == tx0; i++) begin @(negedge clk); #1; end
        @(negedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL drain_idle got busy=%0b expected=0", bus.busy); end
        repeat (50) @(negedge clk);
        #1;
        checks++;
        if (n_init - i0 !== 3 || n_fd !== f0) begin
            failures++; $display("FAIL abort_effect got lines=%0d fd=%0d expected 3 0", n_init - i0, n_fd - f0);
        end
    endtask

    task automatic test_reset_mid_gap();
        int d, tx0;
        int i0 = n_init;
        tx_lat = 10;
        tx0 = n_tx;
        exp_q.push_back('{50, 0, 70, 200});
        kick(50, 130, 20, 70, 200, 40, d);
        for (int i = 0; i < 200 && n_tx == tx0; i++) begin @(negedge clk); #1; end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.line_idx !== 8'd1) begin
            failures++; $display("FAIL gap_state got busy=%0b idx=%0d expected 1 1", bus.busy, bus.line_idx);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (w_outs !== 41'd0) begin failures++; $display("FAIL reset_mid_gap got=%h expected=0", w_outs); end
        rst = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        checks++;
        if (n_init - i0 !== 1 || exp_q.size() !== 0) begin
            failures++; $display("FAIL reset_mid_gap_after got lines=%0d left=%0d expected 1 0", n_init - i0, exp_q.size());
        end
    endtask

`ifdef SCAN_CONTINUOUS_EN
    task automatic test_continuous();
        int d;
        int i0 = n_init;
        int f0 = n_fd;
        tx_lat = 10;
        bus.cont = 1'b1;
        repeat (3) push_frame(50, 70, 20, 9, 40);
        kick(50, 70, 20, 9, 40, 0, d);
        for (int i = 0; i < 500 && n_init < i0 + 5; i++) begin @(negedge clk); #1; end
        bus.abort = 1'b1;
        @(negedge clk); #1;
        bus.abort = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 100 && bus.busy === 1'b1; i++) begin @(negedge clk); #1; end
        checks++;
        if (n_fd - f0 !== 2 || n_init - i0 !== 5 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL continuous got fd=%0d lines=%0d busy=%0b expected 2 5 0", n_fd - f0, n_init - i0, bus.busy);
        end
        bus.cont = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start           = 1'b0;
        bus.abort           = 1'b0;
        bus.cfg_angle_start = '0;
        bus.cfg_angle_end   = '0;
        bus.cfg_angle_step  = '0;
        bus.cfg_r_0         = '0;
        bus.cfg_num_points  = '0;
        bus.cfg_gap         = '0;
`ifdef SCAN_CONTINUOUS_EN
        bus.cont            = 1'b0;
`endif
        test_reset();
        test_frame_basic();
        test_single_line();
        test_cfg_err();
        test_overflow();
        test_abort_drain();
        test_reset_mid_gap();
`ifdef SCAN_CONTINUOUS_EN
        test_continuous();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
